// File: rtl/reg_banda_if.sv
// reg_banda_if: bus bundle for the reg_banda holding register.
//   in       producer -> register : data word to store
//   escribir producer -> register : write strobe, captures `in` on the rising edge
//   leer     consumer -> register : read strobe, loads the stored word into `out`
//   out      register -> consumer : registered output word
// Strobe semantics: both strobes are level-sensitive with no ready/ack. Each
// rising edge where a strobe is high performs exactly one action. There is no
// back-pressure, so a write is never refused and a read never stalls.
interface reg_banda_if #(
  parameter int WIDTH = 25
);
  logic [WIDTH-1:0] in;
  logic             leer;
  logic             escribir;
  logic [WIDTH-1:0] out;

  modport master (output in, output leer, output escribir, input out);
  modport slave  (input in, input leer, input escribir, output out);
endinterface

// File: rtl/reg_banda.sv
// reg_banda: single-entry holding register for one band word, followed by a
// registered output stage.
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high; clears the stored word and the output
//   bus    reg_banda_if.slave (in, escribir, leer -> out)
// A write puts the word into `store`. A read copies `store` to `out`. When both
// strobes are high on the same edge, the read takes the old `store` value.
// There is no bypass, so the shortest write-to-output latency is two edges.
module reg_banda #(
  parameter int WIDTH = 25
) (
  input  logic        clk,
  input  logic        reset,
  reg_banda_if.slave  bus
);

  logic [WIDTH-1:0] store;
  logic [WIDTH-1:0] out_q;

  // Both nonblocking updates read pre-edge values. This ordering gives the
  // read-before-write behaviour on simultaneous strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      store <= '0;
      out_q <= '0;
    end else begin
      if (bus.escribir) store <= bus.in;
      if (bus.leer)     out_q <= store;
    end
  end

  // The output comes straight from a flop, with no combinational path from the inputs.
  assign bus.out = out_q;

endmodule

// File: tb/tb_reg_banda.sv
// tb_reg_banda: directed bench for reg_banda. It uses a vector table with
// hand-computed outputs and a strobe-held sequence checked against an
// expected queue.
module tb_reg_banda;
  localparam int W = 25;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_banda_if #(.WIDTH(W)) bus ();

  reg_banda #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic         esc;
    logic         lee;
    logic [W-1:0] din;
    logic [W-1:0] exp_out;
    string        name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic l, logic [W-1:0] d,
                              logic [W-1:0] x, string n);
    vec_t v;
    v.rst = r; v.esc = e; v.lee = l; v.din = d; v.exp_out = x; v.name = n;
    return v;
  endfunction

  // ---------------- driver ----------------
  // The bench changes inputs on the falling edge and samples 1 time unit after
  // the next rising edge.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [W-1:0] d);
    @(negedge clk);
    reset        = r;
    bus.escribir = e;
    bus.leer     = l;
    bus.in       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: out=0x%07h expected 0x%07h", name, act, exp);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [W-1:0] words[4];
    logic [W-1:0] e;

    reset = 1'b1; bus.escribir = 1'b0; bus.leer = 1'b0; bus.in = '0;

    //             rst  esc  lee  in           expected out  name
    vecs.push_back(mk(1, 0, 0, 25'h00F83E0, 25'h0000000, "reset"));
    vecs.push_back(mk(0, 0, 1, 25'h00F83E0, 25'h0000000, "read_after_reset"));
    vecs.push_back(mk(0, 1, 0, 25'h1FF007D, 25'h0000000, "write_no_output_change"));
    vecs.push_back(mk(0, 0, 0, 25'h1555555, 25'h0000000, "idle_in_toggle_a"));
    vecs.push_back(mk(0, 0, 0, 25'h0AAAAAA, 25'h0000000, "idle_in_toggle_b"));
    vecs.push_back(mk(0, 0, 1, 25'h1555555, 25'h1FF007D, "write_then_read"));
    vecs.push_back(mk(0, 0, 0, 25'h1999999, 25'h1FF007D, "hold_1999999"));
    vecs.push_back(mk(0, 0, 0, 25'h0666666, 25'h1FF007D, "hold_0666666"));
    vecs.push_back(mk(0, 0, 0, 25'h1C71C71, 25'h1FF007D, "hold_1C71C71"));
    vecs.push_back(mk(0, 0, 1, 25'h0000000, 25'h1FF007D, "repeat_read"));
    vecs.push_back(mk(0, 1, 1, 25'h1555555, 25'h1FF007D, "simul_read_old"));
    vecs.push_back(mk(0, 0, 1, 25'h0000000, 25'h1555555, "read_after_simul"));
    vecs.push_back(mk(1, 1, 1, 25'h1FFFFFF, 25'h0000000, "reset_priority"));
    vecs.push_back(mk(0, 0, 1, 25'h1FFFFFF, 25'h0000000, "read_after_midreset"));
    vecs.push_back(mk(0, 1, 0, 25'h1F07C1F, 25'h0000000, "overwrite_first"));
    vecs.push_back(mk(0, 1, 0, 25'h00F83E0, 25'h0000000, "overwrite_second"));
    vecs.push_back(mk(0, 0, 1, 25'h1FFFFFF, 25'h00F83E0, "overwrite_read"));
    vecs.push_back(mk(0, 1, 0, 25'h0000001, 25'h00F83E0, "write_lsb"));
    vecs.push_back(mk(0, 1, 1, 25'h0000002, 25'h0000001, "simul_lsb"));
    vecs.push_back(mk(0, 0, 1, 25'h0000000, 25'h0000002, "read_lsb"));
    vecs.push_back(mk(0, 1, 0, 25'h1FFFFFF, 25'h0000002, "write_all_ones"));
    vecs.push_back(mk(0, 0, 1, 25'h0000000, 25'h1FFFFFF, "read_all_ones"));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].esc, vecs[i].lee, vecs[i].din);
      check(vecs[i].name, bus.out, vecs[i].exp_out);
    end

    // Both strobes held high for several edges. Each edge does one write and
    // one read, so `out` trails the written words by one edge.
    words[0] = 25'h0123456; words[1] = 25'h1ABCDEF;
    words[2] = 25'h0F0F0F0; words[3] = 25'h10F0F0F;
    exp_q.push_back(25'h1FFFFFF);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b1, words[k]);
      e = exp_q.pop_front();
      check($sformatf("held_strobes_%0d", k), bus.out, e);
      exp_q.push_back(words[k]);
    end
    step(1'b0, 1'b0, 1'b1, 25'h0000000);
    e = exp_q.pop_front();
    check("held_strobes_final_read", bus.out, e);

    // Reset in the middle of a long idle: the output clears and the old word is lost.
    step(1'b0, 1'b0, 0, 25'h1555555);
    check("idle_before_reset", bus.out, 25'h10F0F0F);
    step(1'b1, 1'b0, 1'b0, 25'h1555555);
    check("reset_clears_out", bus.out, 25'h0000000);
    step(1'b0, 1'b0, 1'b1, 25'h1555555);
    check("read_lost_word", bus.out, 25'h0000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
